// File: rtl/multicycle_mem_port_if.sv
// Control-unit <-> memory-port bundle: request strobes and addresses in,
// IR/MDR and completion status out.
interface multicycle_mem_port_if #(
    parameter int unsigned XLEN = 32
);
    logic            mem_read;
    logic            mem_write;
    logic            IorD;
    logic            IRWrite;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] alu_addr;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] inst_reg;
    logic [XLEN-1:0] mem_data_reg;
    logic            mem_ready;
    logic            mem_busy;

    modport master (
        output mem_read, mem_write, IorD, IRWrite, pc, alu_addr, write_data,
        input  inst_reg, mem_data_reg, mem_ready, mem_busy
    );

    modport slave (
        input  mem_read, mem_write, IorD, IRWrite, pc, alu_addr, write_data,
        output inst_reg, mem_data_reg, mem_ready, mem_busy
    );
endinterface

// File: rtl/multicycle_mem_port.sv
// Unified instruction/data memory port for the multi-cycle core: word array,
// IR and MDR, fixed access latency, one-cycle mem_ready completion pulse.
module multicycle_mem_port #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned DEPTH   = 16384,
    parameter int unsigned LATENCY = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_mem_port_if.slave   bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              wr_q, wr_d;
    logic              to_ir_q, to_ir_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   ir_q, ir_d;
    logic [XLEN-1:0]   mdr_q, mdr_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;

    logic              mem_we_c;
    logic [XLEN-1:0]   addr_c;
    logic [XLEN-1:0]   rdata_c;
    logic              unused_addr_bits_c;

    logic [XLEN-1:0]   mem_q [DEPTH];

    // Byte offset and bits above the array size are dropped, so addresses wrap.
    assign addr_c             = bus.IorD ? bus.alu_addr : bus.pc;
    assign unused_addr_bits_c = ^{addr_c[XLEN-1:IDX_W+2], addr_c[1:0]};
    assign rdata_c            = mem_q[idx_q];

    // Next-state: accesses use only values latched in IDLE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        wr_d     = wr_q;
        to_ir_d  = to_ir_q;
        wdata_d  = wdata_q;
        ir_d     = ir_q;
        mdr_d    = mdr_q;
        mem_we_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.mem_read || bus.mem_write) begin
                    idx_d   = addr_c[IDX_W+1:2];
                    wr_d    = bus.mem_write;
                    to_ir_d = bus.IRWrite;
                    wdata_d = bus.write_data;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = DONE;
                    if (wr_q) begin
                        mem_we_c = 1'b1;
                    end else if (to_ir_q) begin
                        ir_d = rdata_c;
                    end else begin
                        mdr_d = rdata_c;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d  = (state_d != IDLE);
        ready_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            to_ir_q <= 1'b0;
            wdata_q <= '0;
            ir_q    <= '0;
            mdr_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            to_ir_q <= to_ir_d;
            wdata_q <= wdata_d;
            ir_q    <= ir_d;
            mdr_q   <= mdr_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    // Array is never reset; reset in the final BUSY cycle still blocks the write.
    always_ff @(posedge clk) begin
        if (mem_we_c && !reset) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign bus.inst_reg     = ir_q;
    assign bus.mem_data_reg = mdr_q;
    assign bus.mem_ready    = ready_q;
    assign bus.mem_busy     = busy_q;
endmodule

// File: tb/tb_multicycle_mem_port.sv
// Scoreboard bench for multicycle_mem_port: LATENCY=4 main instance plus a
// LATENCY=1 instance for the held-request cadence.
module tb_multicycle_mem_port;
    localparam int unsigned LAT       = 4;
    localparam int unsigned DEPTH_W   = 16384;
    localparam int          EXP_BUSY  = LAT + 1;
    localparam int          EXP_READY = LAT + 1;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] mdr;
    } exp_t;

    logic clk;
    logic reset;

    multicycle_mem_port_if #(.XLEN(32)) bus  ();
    multicycle_mem_port_if #(.XLEN(32)) bus1 ();

    multicycle_mem_port #(.XLEN(32), .DEPTH(DEPTH_W), .LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    multicycle_mem_port #(.XLEN(32), .DEPTH(DEPTH_W), .LATENCY(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] mdl_mem [int unsigned];
    logic [31:0] mdl_ir;
    logic [31:0] mdl_mdr;
    exp_t        sb_q [$];

    int          obs_busy_cnt;
    int          obs_ready_at;
    int          obs_ready_cnt;
    bit          obs_consec;
    bit          obs_timeout;
    logic [31:0] obs_ir;
    logic [31:0] obs_mdr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model the access, push expected IR/MDR, then drive it and record what the DUT shows.
    task automatic issue(input logic rd, input logic wr, input logic iord, input logic irw,
                         input logic [31:0] pc_v, input logic [31:0] alu_v,
                         input logic [31:0] wd_v, input bit drop);
        logic [31:0] a;
        int unsigned idx;
        exp_t        e;
        bit          prev_ready;
        bit          done;
        a   = iord ? alu_v : pc_v;
        idx = (a >> 2) % DEPTH_W;
        if (wr)       mdl_mem[idx] = wd_v;
        else if (irw) mdl_ir  = mdl_mem[idx];
        else          mdl_mdr = mdl_mem[idx];
        e.ir  = mdl_ir;
        e.mdr = mdl_mdr;
        sb_q.push_back(e);

        @(negedge clk);
        bus.mem_read   = rd;
        bus.mem_write  = wr;
        bus.IorD       = iord;
        bus.IRWrite    = irw;
        bus.pc         = pc_v;
        bus.alu_addr   = alu_v;
        bus.write_data = wd_v;
        @(posedge clk);
        #1;
        if (drop) begin
            bus.mem_read  = 1'b0;
            bus.mem_write = 1'b0;
        end
        obs_busy_cnt  = 0;
        obs_ready_at  = -1;
        obs_ready_cnt = 0;
        obs_consec    = 1'b0;
        obs_timeout   = 1'b1;
        obs_ir        = 'x;
        obs_mdr       = 'x;
        prev_ready    = 1'b0;
        done          = 1'b0;
        for (int i = 1; i <= 40 && !done; i++) begin
            if (i > 1) begin
                @(posedge clk);
                #1;
            end
            if (bus.mem_busy === 1'b1) obs_busy_cnt++;
            if (bus.mem_ready === 1'b1) begin
                if (prev_ready) obs_consec = 1'b1;
                if (obs_ready_cnt == 0) begin
                    obs_ready_at = i;
                    obs_ir       = bus.inst_reg;
                    obs_mdr      = bus.mem_data_reg;
                end
                obs_ready_cnt++;
                bus.mem_read  = 1'b0;
                bus.mem_write = 1'b0;
            end
            prev_ready = (bus.mem_ready === 1'b1);
            if (obs_ready_cnt > 0 && bus.mem_busy === 1'b0) begin
                obs_timeout = 1'b0;
                done        = 1'b1;
            end
        end
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.inst_reg !== 32'h0) begin failures++; $display("FAIL reset_ir got=%h exp=0", bus.inst_reg); end
        checks++; if (bus.mem_data_reg !== 32'h0) begin failures++; $display("FAIL reset_mdr got=%h exp=0", bus.mem_data_reg); end
        checks++; if (bus.mem_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", bus.mem_ready); end
        checks++; if (bus.mem_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.mem_busy); end
        checks++; if (bus1.mem_busy !== 1'b0) begin failures++; $display("FAIL reset_busy1 got=%b exp=0", bus1.mem_busy); end
        @(negedge clk);
        reset   = 1'b0;
        mdl_ir  = 32'h0;
        mdl_mdr = 32'h0;
    endtask

    task automatic test_preload();
        logic [31:0] addrs [3];
        logic [31:0] vals  [3];
        exp_t        e;
        addrs = '{32'h8, 32'h4, 32'h40};
        vals  = '{32'h00A00093, 32'h11111111, 32'hCAFE0040};
        for (int k = 0; k < 3; k++) begin
            issue(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, addrs[k], vals[k], 1'b0);
            e = sb_q.pop_front();
            checks++; if (obs_ready_cnt !== 1 || obs_timeout) begin failures++; $display("FAIL preload_ready[%0d] got=%0d exp=1", k, obs_ready_cnt); end
            checks++; if (obs_busy_cnt !== EXP_BUSY) begin failures++; $display("FAIL preload_busy[%0d] got=%0d exp=%0d", k, obs_busy_cnt, EXP_BUSY); end
            checks++; if (obs_ir !== e.ir || obs_mdr !== e.mdr) begin failures++; $display("FAIL preload_regs[%0d] got=%h/%h exp=%h/%h", k, obs_ir, obs_mdr, e.ir, e.mdr); end
        end
    endtask

    task automatic test_fetch();
        exp_t e;
        issue(1'b1, 1'b0, 1'b0, 1'b1, 32'h8, 32'h0, 32'h0, 1'b0);
        e = sb_q.pop_front();
        checks++; if (obs_busy_cnt !== EXP_BUSY) begin failures++; $display("FAIL fetch_busy got=%0d exp=%0d", obs_busy_cnt, EXP_BUSY); end
        checks++; if (obs_ready_at !== EXP_READY) begin failures++; $display("FAIL fetch_latency got=%0d exp=%0d", obs_ready_at, EXP_READY); end
        checks++; if (obs_ready_cnt !== 1 || obs_consec) begin failures++; $display("FAIL fetch_pulses got=%0d exp=1", obs_ready_cnt); end
        checks++; if (obs_ir !== e.ir) begin failures++; $display("FAIL fetch_ir got=%h exp=%h", obs_ir, e.ir); end
        checks++; if (obs_mdr !== e.mdr) begin failures++; $display("FAIL fetch_mdr got=%h exp=%h", obs_mdr, e.mdr); end
    endtask

    task automatic test_store_load();
        exp_t e;
        issue(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h100, 32'hDEADBEEF, 1'b0);
        e = sb_q.pop_front();
        checks++; if (obs_ready_at !== EXP_READY || obs_ready_cnt !== 1) begin failures++; $display("FAIL store_ready got=%0d exp=%0d", obs_ready_at, EXP_READY); end
        issue(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h103, 32'h0, 1'b0);
        e = sb_q.pop_front();
        checks++; if (obs_mdr !== e.mdr) begin failures++; $display("FAIL load_mdr got=%h exp=%h", obs_mdr, e.mdr); end
        checks++; if (obs_ir !== e.ir) begin failures++; $display("FAIL load_ir got=%h exp=%h", obs_ir, e.ir); end
    endtask

    task automatic test_read_write_both();
        exp_t e;
        issue(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h20, 32'h5, 1'b0);
        e = sb_q.pop_front();
        checks++; if (obs_ready_cnt !== 1 || obs_consec) begin failures++; $display("FAIL both_pulses got=%0d exp=1", obs_ready_cnt); end
        checks++; if (obs_ir !== e.ir || obs_mdr !== e.mdr) begin failures++; $display("FAIL both_regs got=%h/%h exp=%h/%h", obs_ir, obs_mdr, e.ir, e.mdr); end
        issue(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h20, 32'h0, 1'b0);
        e = sb_q.pop_front();
        checks++; if (obs_mdr !== e.mdr) begin failures++; $display("FAIL both_readback got=%h exp=%h", obs_mdr, e.mdr); end
    endtask

    task automatic test_wrap_and_drop();
        exp_t e;
        issue(1'b1, 1'b0, 1'b0, 1'b1, 32'h10004, 32'h0, 32'h0, 1'b0);
        e = sb_q.pop_front();
        checks++; if (obs_ir !== e.ir) begin failures++; $display("FAIL wrap_ir got=%h exp=%h", obs_ir, e.ir); end
        issue(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h8, 32'h0, 1'b1);
        e = sb_q.pop_front();
        checks++; if (obs_ready_cnt !== 1 || obs_ready_at !== EXP_READY) begin failures++; $display("FAIL drop_ready got=%0d@%0d exp=1@%0d", obs_ready_cnt, obs_ready_at, EXP_READY); end
        checks++; if (obs_mdr !== e.mdr) begin failures++; $display("FAIL drop_mdr got=%h exp=%h", obs_mdr, e.mdr); end
    endtask

    task automatic test_reset_mid_write();
        exp_t e;
        int   stray;
        @(negedge clk);
        bus.mem_write  = 1'b1;
        bus.IorD       = 1'b1;
        bus.alu_addr   = 32'h40;
        bus.write_data = 32'h1234;
        @(posedge clk);
        #1;
        bus.mem_write = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++; if (bus.mem_busy !== 1'b0 || bus.mem_ready !== 1'b0) begin failures++; $display("FAIL abort_status got=%b/%b exp=0/0", bus.mem_busy, bus.mem_ready); end
        checks++; if (bus.inst_reg !== 32'h0 || bus.mem_data_reg !== 32'h0) begin failures++; $display("FAIL abort_regs got=%h/%h exp=0/0", bus.inst_reg, bus.mem_data_reg); end
        mdl_ir  = 32'h0;
        mdl_mdr = 32'h0;
        stray   = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.mem_ready !== 1'b0 || bus.mem_busy !== 1'b0) stray++;
        end
        checks++; if (stray !== 0) begin failures++; $display("FAIL abort_stray got=%0d exp=0", stray); end
        issue(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h40, 32'h0, 1'b0);
        e = sb_q.pop_front();
        checks++; if (obs_mdr !== e.mdr) begin failures++; $display("FAIL abort_load got=%h exp=%h", obs_mdr, e.mdr); end
    endtask

    task automatic test_held_request();
        int  pulses;
        int  last;
        bit  bad_gap;
        bit  consec;
        bit  prev;
        @(negedge clk);
        bus1.mem_read = 1'b1;
        bus1.IorD     = 1'b0;
        bus1.IRWrite  = 1'b1;
        bus1.pc       = 32'h0;
        @(posedge clk);
        #1;
        pulses  = 0;
        last    = -1;
        bad_gap = 1'b0;
        consec  = 1'b0;
        prev    = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            if (i > 1) begin
                @(posedge clk);
                #1;
            end
            if (bus1.mem_ready === 1'b1) begin
                if (prev) consec = 1'b1;
                if (last >= 0 && i - last != 3) bad_gap = 1'b1;
                if (last < 0 && i != 2) bad_gap = 1'b1;
                last = i;
                pulses++;
            end
            prev = (bus1.mem_ready === 1'b1);
        end
        bus1.mem_read = 1'b0;
        checks++; if (pulses !== 5) begin failures++; $display("FAIL held_pulses got=%0d exp=5", pulses); end
        checks++; if (bad_gap) begin failures++; $display("FAIL held_period got=irregular exp=every_3rd"); end
        checks++; if (consec) begin failures++; $display("FAIL held_consec got=1 exp=0"); end
    endtask

    initial begin
        reset          = 1'b1;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.IorD       = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.pc         = 32'h0;
        bus.alu_addr   = 32'h0;
        bus.write_data = 32'h0;
        bus1.mem_read   = 1'b0;
        bus1.mem_write  = 1'b0;
        bus1.IorD       = 1'b0;
        bus1.IRWrite    = 1'b0;
        bus1.pc         = 32'h0;
        bus1.alu_addr   = 32'h0;
        bus1.write_data = 32'h0;
        mdl_ir  = 32'h0;
        mdl_mdr = 32'h0;

        test_reset();
        test_preload();
        test_fetch();
        test_store_load();
        test_read_write_both();
        test_wrap_and_drop();
        test_reset_mid_write();
        test_held_request();

        checks++; if (sb_q.size() !== 0) begin failures++; $display("FAIL scoreboard_left got=%0d exp=0", sb_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multicycle_mem_port.md
Name: multicycle_mem_port

Overview:
- Unified instruction/data memory port for the multi-cycle RISC-V core. Sits directly downstream of the control unit's memory strobes (mem_read, mem_write, IorD, IRWrite).
- Owns the word memory array, the instruction register (IR) and the memory data register (MDR).
- Models a fixed multi-cycle access latency. Reports completion to the controller with a one-cycle mem_ready pulse, so the controller FSM can hold IF/MEM states until the access finishes.

Parameters:
- XLEN, 32, data and address width in bits.
- DEPTH, 16384, number of 32-bit words in the array; power of two.
- LATENCY, 4, number of BUSY cycles per access; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- mem_read  input  1  read request strobe from control unit.
- mem_write  input  1  write request strobe from control unit.
- IorD  input  1  address select: 0 = pc (fetch), 1 = alu_addr (data).
- IRWrite  input  1  destination for a completed read: 1 = IR, 0 = MDR.
- pc  input  XLEN  fetch address.
- alu_addr  input  XLEN  data address (ALUOut).
- write_data  input  XLEN  store data (rs2 value).
- inst_reg  output  XLEN  instruction register.
- mem_data_reg  output  XLEN  memory data register.
- mem_ready  output  1  one-cycle completion pulse.
- mem_busy  output  1  high while an access is in flight (BUSY or DONE).

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, counter=0, inst_reg=0, mem_data_reg=0, mem_ready=0, mem_busy=0.
  - Array contents are not reset. An in-flight access is aborted; a pending write is discarded and never reaches the array.
- Addressing:
  - addr = IorD ? alu_addr : pc.
  - word index = addr[log2(DEPTH)+1:2]; addr[1:0] ignored.
  - Addresses beyond DEPTH words wrap modulo DEPTH.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If mem_read|mem_write: latch the request into internal registers (word index, op, write_data, IRWrite), set counter=LATENCY-1, go to BUSY.
  - If mem_read and mem_write are both high: the access is a write; the read is dropped.
  - Otherwise remain in IDLE.
- BUSY:
  - Input strobes are ignored; deasserting them does not cancel the access.
  - counter!=0: decrement.
  - counter==0: perform the access using the latched values only, then go to DONE.
    - Write: array[idx] <= wdata.
    - Read with latched IRWrite=1: inst_reg <= array[idx].
    - Read with latched IRWrite=0: mem_data_reg <= array[idx].
- DONE: mem_ready=1 for exactly this cycle; go to IDLE. A request present during DONE is ignored and is re-evaluated in IDLE on the next cycle.
- Latency: request first sampled in IDLE at cycle c gives BUSY for cycles c+1..c+LATENCY and mem_ready high in cycle c+LATENCY+1. The IR/MDR value is visible in that same cycle.
- mem_busy = (state!=IDLE), registered via the state.
- inst_reg changes only on a completed fetch; mem_data_reg changes only on a completed data read. Neither changes on a write.
- Read-after-write to the same word in consecutive transactions returns the new data.
- mem_ready is never asserted in IDLE or BUSY, and never for two consecutive cycles.

Test Plan:
- Fetch, LATENCY=4: preload array[2]=0x00A00093; mem_read=1, IorD=0, IRWrite=1, pc=0x8 at cycle 1 -> mem_busy cycles 2-6; mem_ready only in cycle 6; inst_reg=0x00A00093 in cycle 6; mem_data_reg unchanged (0).
- Store then load: write_data=0xDEADBEEF, alu_addr=0x100, mem_write=1, IorD=1 -> ready after 4 BUSY cycles. Then mem_read=1, IorD=1, IRWrite=0, alu_addr=0x103 -> mem_data_reg=0xDEADBEEF; inst_reg unchanged.
- Simultaneous read+write at 0x20 with write_data=0x5 -> array[8]=0x5; mem_data_reg and inst_reg unchanged; single mem_ready pulse.
- Reset mid-write: start store 0x1234 to 0x40, assert reset in second BUSY cycle -> next cycle IDLE, outputs 0, no mem_ready; subsequent load of 0x40 returns the preloaded value, not 0x1234.
- Wrap and strobe drop: DEPTH=16384, fetch at pc=0x10004 -> returns array[1]. In a separate access, deassert mem_read in the first BUSY cycle -> access still completes with a mem_ready pulse.
- Held request: keep mem_read=1 continuously, LATENCY=1 -> mem_ready pulses every 3rd cycle (IDLE, BUSY, DONE); never high for two consecutive cycles.
